// File: rtl/clause_loader.sv
// Packs a serial literal stream into one clause_database slot entry per clause,
// dropping duplicate literals and discarding tautologies or oversize clauses.
module clause_loader #(
  parameter int unsigned VPC = 5,
  parameter int unsigned VB  = 8,
  parameter int unsigned CB  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lit_valid,
  output logic              lit_ready,
  input  logic [VB-1:0]     lit_var,
  input  logic              lit_pole,
  input  logic              lit_last,
  input  logic              db_full,
  output logic              push,
  output logic [VPC-1:0]    mask_out,
  output logic [VPC-1:0]    pole_out,
  output logic [VPC*VB-1:0] var_out,
  output logic [CB:0]       clause_count,
  output logic              dropped,
  output logic              error
);

  typedef enum logic [1:0] {COLLECT, EMIT, DRAIN} state_t;

  localparam int unsigned CW        = $clog2(VPC + 1);
  localparam logic [CB:0] COUNT_MAX = {1'b1, {CB{1'b0}}};
  localparam logic [CB:0] COUNT_ONE = {{CB{1'b0}}, 1'b1};

  state_t state, state_n;

  logic [VPC-1:0]    acc_mask, acc_pole;
  logic [VPC*VB-1:0] acc_var;
  logic [CW-1:0]     acc_cnt;
  logic              acc_taut;

  logic              accept, hit_same, hit_opp, is_new, overflow;
  logic [VPC-1:0]    fin_mask, fin_pole;
  logic [VPC*VB-1:0] fin_var;
  logic [CW-1:0]     fin_cnt;
  logic              fin_taut;

  // Ready only while collecting or draining, and never during reset.
  always_comb begin
    lit_ready = reset && (state == COLLECT || state == DRAIN);
    accept    = lit_valid && lit_ready;
  end

  // Compare the incoming literal against every filled slot and form the updated clause.
  always_comb begin
    hit_same = 1'b0;
    hit_opp  = 1'b0;
    for (int unsigned i = 0; i < VPC; i++) begin
      if (acc_mask[i] && acc_var[i*VB +: VB] == lit_var) begin
        if (acc_pole[i] == lit_pole) hit_same = 1'b1;
        else                         hit_opp  = 1'b1;
      end
    end
    is_new   = !(hit_same || hit_opp);
    overflow = is_new && (acc_cnt == CW'(VPC));
    fin_mask = acc_mask;
    fin_pole = acc_pole;
    fin_var  = acc_var;
    fin_cnt  = acc_cnt;
    fin_taut = acc_taut || hit_opp;
    if (is_new && !overflow) begin
      for (int unsigned i = 0; i < VPC; i++) begin
        if (CW'(i) == acc_cnt) begin
          fin_mask[i]          = 1'b1;
          fin_pole[i]          = lit_pole;
          fin_var[i*VB +: VB]  = lit_var;
        end
      end
      fin_cnt = acc_cnt + CW'(1);
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (overflow)      state_n = lit_last ? COLLECT : DRAIN;
          else if (lit_last) state_n = EMIT;
        end
      end
      EMIT:    state_n = COLLECT;
      DRAIN:   if (accept && lit_last) state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
  end

  // Clause accumulators; wiped after emit, while draining, and on overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_mask <= '0;
      acc_pole <= '0;
      acc_var  <= '0;
      acc_cnt  <= '0;
      acc_taut <= 1'b0;
    end else if (state == EMIT || state == DRAIN || (state == COLLECT && accept && overflow)) begin
      acc_mask <= '0;
      acc_pole <= '0;
      acc_var  <= '0;
      acc_cnt  <= '0;
      acc_taut <= 1'b0;
    end else if (state == COLLECT && accept) begin
      acc_mask <= fin_mask;
      acc_pole <= fin_pole;
      acc_var  <= fin_var;
      acc_cnt  <= fin_cnt;
      acc_taut <= fin_taut;
    end
  end

  // Outcome registers: the push/drop decision is taken on the last-beat edge so it is
  // visible during EMIT; the count advances on the edge that ends the push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      push         <= 1'b0;
      dropped      <= 1'b0;
      error        <= 1'b0;
      mask_out     <= '0;
      pole_out     <= '0;
      var_out      <= '0;
      clause_count <= '0;
    end else begin
      push    <= 1'b0;
      dropped <= 1'b0;
      if (state == EMIT && push) clause_count <= clause_count + COUNT_ONE;
      if (state == COLLECT && accept) begin
        if (overflow) begin
          error <= 1'b1;
          if (lit_last) dropped <= 1'b1;
        end else if (lit_last) begin
          if (fin_taut) begin
            dropped <= 1'b1;
          end else if (db_full || clause_count == COUNT_MAX) begin
            dropped <= 1'b1;
            error   <= 1'b1;
          end else begin
            push     <= 1'b1;
            mask_out <= fin_mask;
            pole_out <= fin_pole;
            var_out  <= fin_var;
          end
        end
      end
      if (state == DRAIN && accept && lit_last) dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clause_loader.sv
// Scoreboard bench for clause_loader with VPC=5, VB=8, CB=3.
module tb_clause_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lit_valid = 1'b0;
  logic        lit_ready;
  logic [7:0]  lit_var = '0;
  logic        lit_pole = 1'b0;
  logic        lit_last = 1'b0;
  logic        db_full = 1'b0;
  logic        push;
  logic [4:0]  mask_out, pole_out;
  logic [39:0] var_out;
  logic [3:0]  clause_count;
  logic        dropped, error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_push;
    logic [4:0]  mask;
    logic [4:0]  pole;
    logic [39:0] vars;
    logic [3:0]  cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];

  clause_loader #(.VPC(5), .VB(8), .CB(3)) dut (
    .clock(clock), .reset(reset), .lit_valid(lit_valid), .lit_ready(lit_ready),
    .lit_var(lit_var), .lit_pole(lit_pole), .lit_last(lit_last), .db_full(db_full),
    .push(push), .mask_out(mask_out), .pole_out(pole_out), .var_out(var_out),
    .clause_count(clause_count), .dropped(dropped), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [4:0] m, input logic [4:0] p, input logic [39:0] v,
                          input logic [3:0] c, input logic e);
    exp_t x;
    x.is_push = 1'b1; x.mask = m; x.pole = p; x.vars = v; x.cnt = c; x.err = e;
    sb.push_back(x);
  endtask

  task automatic exp_drop(input logic [3:0] c, input logic e);
    exp_t x;
    x.is_push = 1'b0; x.mask = '0; x.pole = '0; x.vars = '0; x.cnt = c; x.err = e;
    sb.push_back(x);
  endtask

  // Drive one beat at a falling edge and hold it until a rising edge accepts it.
  task automatic send(input logic [7:0] v, input logic p, input logic l);
    bit done = 0;
    @(negedge clock);
    lit_valid = 1'b1; lit_var = v; lit_pole = p; lit_last = l;
    for (int n = 0; n < 50 && !done; n++) begin
      if (lit_ready) begin
        @(posedge clock);
        done = 1;
      end else begin
        @(negedge clock);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout var=%0d", v);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    lit_valid = 1'b0; lit_last = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every push or drop pulse is matched against the next expected outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && (push || dropped)) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual push=%0b dropped=%0b expected none", push, dropped);
        end else begin
          e = sb.pop_front();
          chk("push_vs_drop", {62'd0, push, dropped}, {62'd0, e.is_push, !e.is_push});
          if (e.is_push) begin
            chk("mask_out", 64'(mask_out), 64'(e.mask));
            chk("pole_out", 64'(pole_out), 64'(e.pole));
            chk("var_out", 64'(var_out), 64'(e.vars));
          end
          chk("count_at_outcome", 64'(clause_count), 64'(e.cnt));
          chk("error_at_outcome", 64'(error), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #1;
    chk("reset_lit_ready", 64'(lit_ready), 64'd0);
    chk("reset_push", 64'(push), 64'd0);
    chk("reset_count", 64'(clause_count), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_var_out", 64'(var_out), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    // Basic three-literal clause.
    exp_push(5'b00111, 5'b00010, {8'd0, 8'd0, 8'd9, 8'd7, 8'd3}, 4'd0, 1'b0);
    send(8'd3, 1'b0, 1'b0); send(8'd7, 1'b1, 1'b0); send(8'd9, 1'b0, 1'b1);

    // Duplicate on last beat still finalizes; ready drops during EMIT.
    exp_push(5'b00001, 5'b00000, {32'd0, 8'd4}, 4'd1, 1'b0);
    send(8'd4, 1'b0, 1'b0); send(8'd4, 1'b0, 1'b1);
    @(negedge clock);
    chk("emit_lit_ready_low", 64'(lit_ready), 64'd0);

    // Tautology is discarded.
    exp_drop(4'd2, 1'b0);
    send(8'd4, 1'b0, 1'b0); send(8'd4, 1'b1, 1'b1);

    // Single negated literal.
    exp_push(5'b00001, 5'b00001, {32'd0, 8'd5}, 4'd2, 1'b0);
    send(8'd5, 1'b1, 1'b1);

    // Exactly VPC distinct literals with an interior duplicate.
    exp_push(5'b11111, 5'b01010, {8'd6, 8'd4, 8'd3, 8'd2, 8'd1}, 4'd3, 1'b0);
    send(8'd1, 1'b0, 1'b0); send(8'd2, 1'b1, 1'b0); send(8'd3, 1'b0, 1'b0);
    send(8'd2, 1'b1, 1'b0); send(8'd4, 1'b1, 1'b0); send(8'd6, 1'b0, 1'b1);

    // Six distinct literals: overflow on the last beat.
    exp_drop(4'd4, 1'b1);
    for (int k = 0; k < 6; k++) send(8'(10 + k), 1'b0, k == 5);

    // Next clause loads normally.
    exp_push(5'b00011, 5'b00000, {24'd0, 8'd21, 8'd20}, 4'd4, 1'b1);
    send(8'd20, 1'b0, 1'b0); send(8'd21, 1'b0, 1'b1);

    // Seven distinct literals: drain after the sixth.
    exp_drop(4'd5, 1'b1);
    for (int k = 0; k < 6; k++) send(8'(30 + k), 1'b0, 1'b0);
    #1;
    chk("drain_lit_ready_high", 64'(lit_ready), 64'd1);
    send(8'd36, 1'b0, 1'b1);
    idle();
    wait_drain();
    chk("count_before_reset", 64'(clause_count), 64'd5);

    // Reset mid-clause.
    send(8'd60, 1'b0, 1'b0); send(8'd61, 1'b0, 1'b0);
    @(negedge clock);
    lit_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset_count", 64'(clause_count), 64'd0);
    chk("midreset_error", 64'(error), 64'd0);
    chk("midreset_mask_out", 64'(mask_out), 64'd0);
    chk("midreset_lit_ready", 64'(lit_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Fresh clause packs from slot 0.
    exp_push(5'b00011, 5'b00001, {24'd0, 8'd51, 8'd50}, 4'd0, 1'b0);
    send(8'd50, 1'b1, 1'b0); send(8'd51, 1'b0, 1'b1);

    // Database full at emit.
    send(8'd40, 1'b0, 1'b0);
    @(negedge clock);
    db_full = 1'b1;
    exp_drop(4'd1, 1'b1);
    send(8'd41, 1'b1, 1'b1);
    idle();
    @(negedge clock);
    db_full = 1'b0;

    // Fill to saturation, then one more clause is dropped.
    for (int k = 1; k < 8; k++) begin
      exp_push(5'b00001, 5'b00000, {32'd0, 8'(70 + k)}, 4'(k), 1'b1);
      send(8'(70 + k), 1'b0, 1'b1);
    end
    exp_drop(4'd8, 1'b1);
    send(8'd99, 1'b0, 1'b1);
    idle();
    wait_drain();
    chk("count_saturated", 64'(clause_count), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
